rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- N-channel, W-bit arbitrated multiplexer with a valid/ready handshake on every input and on the output.
- Selects one requesting channel per cycle and registers its word into a single-entry output stage.
- Tags the output word with the granted channel index.
- Used wherever several producers share one consumer: writeback ports, memory request merge, debug buses.

Parameters:
- N, 4, number of input channels; legal 2..32, need not be a power of two.
- W, 32, data width per channel.
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SELW, derived as clog2(N), width of the channel-index fields; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N  per-channel request; bit i belongs to channel i.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_ready  out  N  per-channel accept; at most one bit high per cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered word.
- out_sel  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. A word held at reset is discarded.
- Load enable: load = ~out_valid | out_ready.
- Grant, combinational from in_valid and ptr:
  - MODE 0: first i with in_valid[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - MODE 1: lowest i with in_valid[i]=1; ptr is ignored.
- in_ready[i] = load & grant[i].
  - in_ready has a combinational path from out_ready and in_valid.
  - in_ready never depends on in_data.
- Transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. That edge sets:
  - out_valid=1
  - out_data=in_data[i]
  - out_sel=i
  - MODE 0 only: ptr = (i+1) mod N; at i=N-1, ptr wraps to 0 (also for non-power-of-two N).
- Output drain: out_valid & out_ready with no new grant sets out_valid=0. out_data and out_sel hold their last value.
- Simultaneous drain and load in one cycle: the new word replaces the old. Sustained throughput is 1 word/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_sel and out_valid are held stable.
  - All in_ready=0; ptr is unchanged.
- No requests: in_ready=0, ptr unchanged, output drains normally.
- Producers must hold in_valid and in_data until they transfer. A producer that drops in_valid early simply loses arbitration; no error is flagged.
- Fairness (MODE 0): with all N channels continuously valid, each channel is granted exactly once per N consecutive transfers.
- No combinational path from in_data to any output.
- X on in_data of non-granted channels must not propagate to out_data.

Test Plan:
- Reset mid-stall: load word from ch2 (N=4), hold out_ready=0, assert rst_n=0 -> out_valid=0, out_data=0, out_sel=0 immediately (async); after release, first grant with all valid goes to ch0.
- Round-robin fairness: N=4, MODE 0, all in_valid=1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; one word per cycle; in_data[i]=0xA0+i appears on out_data one cycle after each grant.
- Non-power-of-two wrap: N=5, only ch4 and ch1 valid, out_ready=1 -> grants 1,4,1,4; ptr wraps 4->0 with ch0 idle.
- Backpressure: N=4, ch3 sends 0xDEADBEEF, out_ready=0 for 5 cycles while ch0..2 are valid -> out_data=0xDEADBEEF and out_sel=3 stable, in_ready=0000. On out_ready=1, next grant is ch0 and in_ready=0001 in the same cycle.
- Fixed priority: MODE 1, N=4, in_valid=1010 then 1011 -> grants ch1 then ch0; ch3 starves while ch1 stays valid.
- Drain without refill: one transfer from ch1, then in_valid=0, out_ready=1 -> out_valid high one cycle, then 0; out_data retains the ch1 value; ptr=2.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer feeding a single registered output stage.
// Grant is round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
module rr_arb_mux #(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int MODE = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  localparam int SW1 = SELW + 1;

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] base;
  logic [SELW-1:0] gidx;
  logic [SELW:0]   scan;
  logic [N-1:0]    grant;
  logic            gany;
  logic            load;
  logic [W-1:0]    gdata;

  assign base = (MODE == 0) ? ptr : '0;
  assign load = ~out_valid | out_ready;
  assign in_ready = {N{load}} & grant;

  // Scan channels starting at base, wrapping modulo N so non-power-of-two N works.
  always_comb begin
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, base} + SW1'(k);
      if (scan >= SW1'(N))
        scan = scan - SW1'(N);
      if (!gany && in_valid[scan[SELW-1:0]]) begin
        gany                  = 1'b1;
        grant[scan[SELW-1:0]] = 1'b1;
        gidx                  = scan[SELW-1:0];
      end
    end
  end

  // AND-OR mux keeps X on non-granted channels away from out_data.
  always_comb begin
    gdata = '0;
    for (int i = 0; i < N; i++)
      gdata = gdata | ({W{grant[i]}} & in_data[i*W +: W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= gany;
      if (gany) begin
        out_data <= gdata;
        out_sel  <= gidx;
        if (MODE == 0)
          ptr <= (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);
      end
    end
  end

endmodule
